// File: rtl/mem_map_pkg.sv
// Memory-stage address map: peripheral base, register offsets, TCON bit
// positions and write-back source encodings.
package mem_map_pkg;

  localparam logic [31:0] PeriphBase = 32'h4000_0000;

  localparam logic [7:0] OffTh      = 8'h00;
  localparam logic [7:0] OffTl      = 8'h04;
  localparam logic [7:0] OffTcon    = 8'h08;
  localparam logic [7:0] OffLed     = 8'h0C;
  localparam logic [7:0] OffSwitch  = 8'h10;
  localparam logic [7:0] OffDigi    = 8'h14;
  localparam logic [7:0] OffSystick = 8'h18;

  localparam int unsigned TconEn    = 0;
  localparam int unsigned TconIrqEn = 1;
  localparam int unsigned TconIrq   = 2;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbMem  = 2'd1,
    WbPc   = 2'd2,
    WbRsvd = 2'd3
  } mem2reg_e;

  // Peripheral window is the 256-byte page at PeriphBase.
  function automatic logic is_periph(input logic [31:0] addr);
    return addr[31:8] == PeriphBase[31:8];
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM: one synchronous write port, asynchronous read.
module data_ram #(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned RAM_AW    = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [RAM_AW-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data RAM / peripheral access (timer, LED, switch, digi,
// systick) and the MEM/WB pipeline register.
module mem_stage
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned RAM_AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_m,
  input  logic [31:0] wdata_m,
  input  logic [31:0] pc_m,
  input  logic        mem_rd_m,
  input  logic        mem_wr_m,
  input  logic [1:0]  mem2reg_m,
  input  logic        reg_wr_m,
  input  logic [4:0]  addr_m,
  input  logic [7:0]  switch,
  output logic [31:0] data_w,
  output logic        reg_wr_w,
  output logic [4:0]  addr_w,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  logic [31:0] th_q, th_d, tl_q, tl_d, systick_q, systick_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] data_w_q, data_w_d;
  logic        reg_wr_w_q;
  logic [4:0]  addr_w_q;

  logic              ram_sel, per_sel, ram_we, per_we, ovf, ovf_set;
  logic [7:0]        off;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_rdata, per_rdata, rdata;
  logic              unused_addr_lsb;

  // Byte-address bits [1:0] are ignored: word access only.
  assign unused_addr_lsb = ^alu_m[1:0];

  assign ram_sel  = {2'b00, alu_m[31:2]} < 32'(RAM_WORDS);
  assign per_sel  = is_periph(alu_m);
  assign off      = {alu_m[7:2], 2'b00};
  assign ram_addr = alu_m[RAM_AW+1:2];
  assign ram_we   = mem_wr_m && ram_sel;
  assign per_we   = mem_wr_m && per_sel;

  data_ram #(
    .RAM_WORDS (RAM_WORDS),
    .RAM_AW    (RAM_AW)
  ) u_data_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_addr),
    .wdata_i (wdata_m),
    .raddr_i (ram_addr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    per_rdata = 32'h0;
    case (off)
      OffTh:      per_rdata = th_q;
      OffTl:      per_rdata = tl_q;
      OffTcon:    per_rdata = {29'h0, tcon_q};
      OffLed:     per_rdata = {24'h0, led_q};
      OffSwitch:  per_rdata = {24'h0, switch};
      OffDigi:    per_rdata = {20'h0, digi_q};
      OffSystick: per_rdata = systick_q;
      default:    per_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (mem_rd_m) begin
      if (ram_sel) begin
        rdata = ram_rdata;
      end else if (per_sel) begin
        rdata = per_rdata;
      end
    end
  end

  always_comb begin
    data_w_d = alu_m;
    case (mem2reg_m)
      WbMem:   data_w_d = rdata;
      WbPc:    data_w_d = pc_m;
      default: data_w_d = alu_m;
    endcase
  end

  assign ovf     = tcon_q[TconEn] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set = ovf && tcon_q[TconIrqEn];

  // Timer update first; software writes then override (TL write beats reload).
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;
    if (tcon_q[TconEn]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (ovf_set) begin
      tcon_d[TconIrq] = 1'b1;
    end
    if (per_we) begin
      case (off)
        OffTh:   th_d = wdata_m;
        OffTl:   tl_d = wdata_m;
        OffTcon: tcon_d = {wdata_m[TconIrq] | ovf_set, wdata_m[TconIrqEn], wdata_m[TconEn]};
        OffLed:  led_d = wdata_m[7:0];
        OffDigi: digi_d = wdata_m[11:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q       <= 32'h0;
      tl_q       <= 32'h0;
      tcon_q     <= 3'h0;
      led_q      <= 8'h0;
      digi_q     <= 12'h0;
      systick_q  <= 32'h0;
      data_w_q   <= 32'h0;
      reg_wr_w_q <= 1'b0;
      addr_w_q   <= 5'h0;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      led_q      <= led_d;
      digi_q     <= digi_d;
      systick_q  <= systick_d;
      data_w_q   <= data_w_d;
      reg_wr_w_q <= reg_wr_m;
      addr_w_q   <= addr_m;
    end
  end

  assign data_w   = data_w_q;
  assign reg_wr_w = reg_wr_w_q;
  assign addr_w   = addr_w_q;
  assign led      = led_q;
  assign digi     = digi_q;
  assign irq      = tcon_q[TconIrq];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB triples are queued when a
// cycle is driven and compared once the edge has produced them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_m, wdata_m, pc_m;
  logic        mem_rd_m, mem_wr_m, reg_wr_m;
  logic [1:0]  mem2reg_m;
  logic [4:0]  addr_m;
  logic [7:0]  switch;
  logic [31:0] data_w;
  logic        reg_wr_w;
  logic [4:0]  addr_w;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk       (clk),
    .reset     (reset),
    .alu_m     (alu_m),
    .wdata_m   (wdata_m),
    .pc_m      (pc_m),
    .mem_rd_m  (mem_rd_m),
    .mem_wr_m  (mem_wr_m),
    .mem2reg_m (mem2reg_m),
    .reg_wr_m  (reg_wr_m),
    .addr_m    (addr_m),
    .switch    (switch),
    .data_w    (data_w),
    .reg_wr_w  (reg_wr_w),
    .addr_w    (addr_w),
    .led       (led),
    .digi      (digi),
    .irq       (irq)
  );

  typedef struct {
    logic [31:0] data;
    logic        rw;
    logic [4:0]  addr;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] PTh = 32'h4000_0000, PTl = 32'h4000_0004, PTcon = 32'h4000_0008;
  localparam logic [31:0] PLed = 32'h4000_000C, PSw = 32'h4000_0010, PDigi = 32'h4000_0014;
  localparam logic [31:0] PTick = 32'h4000_0018;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                     input logic rd, input logic wr, input logic [1:0] m2r, input logic rw,
                     input logic [4:0] a, input logic [31:0] exp_data, input string tag);
    exp_t e;
    @(negedge clk);
    alu_m = alu; wdata_m = wd; pc_m = pc; mem_rd_m = rd; mem_wr_m = wr;
    mem2reg_m = m2r; reg_wr_m = rw; addr_m = a;
    e.data = exp_data; e.rw = rw; e.addr = a; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".data"}, data_w, e.data);
    chk({e.tag, ".rw"}, {31'h0, reg_wr_w}, {31'h0, e.rw});
    chk({e.tag, ".addr"}, {27'h0, addr_w}, {27'h0, e.addr});
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input string tag);
    cyc(a, d, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0, a, tag);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cyc(a, 32'h0, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 5'd3, exp, tag);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".data_w"}, data_w, 32'h0);
    chk({tag, ".reg_wr_w"}, {31'h0, reg_wr_w}, 32'h0);
    chk({tag, ".addr_w"}, {27'h0, addr_w}, 32'h0);
    chk({tag, ".led"}, {24'h0, led}, 32'h0);
    chk({tag, ".digi"}, {20'h0, digi}, 32'h0);
    chk({tag, ".irq"}, {31'h0, irq}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    alu_m = '0; wdata_m = '0; pc_m = '0; mem_rd_m = 1'b0; mem_wr_m = 1'b0;
    mem2reg_m = 2'd0; reg_wr_m = 1'b0; addr_m = '0; switch = 8'h81;
    #3;
    chk_outs_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // RAM store then load, write-back source select.
    st(32'h10, 32'hDEAD_BEEF, "st10");
    ld(32'h10, 32'hDEAD_BEEF, "ld10");
    cyc(32'h1234, 32'h0, 32'h44, 1'b0, 1'b0, 2'd2, 1'b1, 5'd31, 32'h44, "wb_pc");
    cyc(32'h7, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd5, 32'h7, "wb_alu");
    cyc(32'h9, 32'h0, 32'h0, 1'b0, 1'b0, 2'd3, 1'b1, 5'd6, 32'h9, "wb_rsvd");
    cyc(32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1, 1'b1, 5'd7, 32'h0, "wb_mem_nord");

    // Load and store together: read sees the old word, next load the new one.
    st(32'h20, 32'hAAAA_0001, "st20a");
    cyc(32'h20, 32'hBBBB_0002, 32'h0, 1'b1, 1'b1, 2'd1, 1'b1, 5'd8, 32'hAAAA_0001, "ldst20");
    ld(32'h20, 32'hBBBB_0002, "ld20b");

    // LED, digi, switch.
    st(PLed, 32'hFFFF_FF5A, "st_led");
    st(PDigi, 32'h1234_5ABC, "st_digi");
    chk("led", {24'h0, led}, 32'h5A);
    chk("digi", {20'h0, digi}, 32'hABC);
    ld(PSw, 32'h81, "ld_sw");
    st(PSw, 32'hFF, "st_sw");
    ld(PSw, 32'h81, "ld_sw2");
    ld(PLed, 32'h5A, "ld_led");
    ld(PDigi, 32'hABC, "ld_digi");

    // Unmapped addresses and the RAM boundary.
    st(32'h0, 32'hCAFE_F00D, "st0");
    st(32'h3FC, 32'h1357_9BDF, "st3fc");
    st(32'h400, 32'h1111_1111, "st400");
    st(32'h4000_0100, 32'h2222_2222, "stp100");
    st(32'h4000_001C, 32'h3333_3333, "stp1c");
    ld(32'h400, 32'h0, "ld400");
    ld(32'h4000_0100, 32'h0, "ldp100");
    ld(32'h4000_001C, 32'h0, "ldp1c");
    ld(32'h0, 32'hCAFE_F00D, "ld0");
    ld(32'h3FC, 32'h1357_9BDF, "ld3fc");

    // Timer: TCON write commits at edge E0.
    st(PTh, 32'hFFFF_FFFC, "st_th");
    st(PTl, 32'hFFFF_FFFE, "st_tl");
    st(PTcon, 32'h3, "st_tcon");
    chk("irq_e0", {31'h0, irq}, 32'h0);
    cyc(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, "idle_e1");
    chk("irq_e1", {31'h0, irq}, 32'h0);
    ld(PTl, 32'hFFFF_FFFF, "ld_tl_e2");
    chk("irq_e2", {31'h0, irq}, 32'h1);
    ld(PTl, 32'hFFFF_FFFC, "ld_tl_reload");
    ld(PTcon, 32'h7, "ld_tcon");
    st(PTcon, 32'h3, "clr_irq");
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    // Overflow coincides with a TCON write of bit2=0: overflow still sets it.
    st(PTcon, 32'h3, "tcon_vs_ovf");
    chk("irq_ovf_or", {31'h0, irq}, 32'h1);
    st(PTl, 32'hFFFF_FFFF, "st_tl_ff");
    // Overflow coincides with a TL write: the write wins over the reload.
    st(PTl, 32'h100, "tl_vs_ovf");
    ld(PTl, 32'h100, "ld_tl_win");

    // Asynchronous reset mid-run.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_outs_zero("async_rst");
    @(posedge clk);
    #1;
    chk("rst_hold", data_w, 32'h0);
    #2 reset = 1'b1;
    ld(PTick, 32'h0, "tick0");
    ld(PTick, 32'h1, "tick1");
    ld(PTl, 32'h0, "tl_after_rst");
    ld(PTcon, 32'h0, "tcon_after_rst");
    ld(PTh, 32'h0, "th_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
